// File: rtl/multi_digit_bcd_counter.sv
// Cascaded up/down counter of DIGITS 4-bit digits, each of modulus RADIX, with
// range-checked parallel load and either wrap or saturate at the ends of range.
module multi_digit_bcd_counter #(
    parameter int DIGITS   = 4,
    parameter int RADIX    = 10,
    parameter int SATURATE = 0
) (
    input  logic                CLK,
    input  logic                MR_N,
    input  logic [4*DIGITS-1:0] D,
    input  logic                PL,
    input  logic                CE,
    input  logic                UP,
    input  logic                DN,
    output logic [4*DIGITS-1:0] Q,
    output logic                TCU,
    output logic                TCD,
    output logic                AT_MAX,
    output logic                AT_MIN,
    output logic                LOAD_ERR
);

    localparam logic [3:0] MAX_DIGIT = 4'(RADIX - 1);
    localparam logic [4:0] RADIX_W   = 5'(RADIX);
    localparam logic       SAT       = (SATURATE != 0);

    function automatic logic digit_valid(input logic [3:0] digit);
        return ({1'b0, digit} < RADIX_W);
    endfunction

    logic [4*DIGITS-1:0] q_r;
    logic                tcu_r;
    logic                tcd_r;
    logic                load_err_r;

    logic [4*DIGITS-1:0] q_up_s;
    logic [4*DIGITS-1:0] q_dn_s;
    logic [4*DIGITS-1:0] q_load_s;
    logic                carry_s;
    logic                borrow_s;
    logic                load_bad_s;
    logic                at_max_s;
    logic                at_min_s;
    logic                step_up_s;
    logic                step_dn_s;

    // Full ripple increment/decrement: a digit moves only while carry/borrow is live.
    always_comb begin
        q_up_s   = q_r;
        q_dn_s   = q_r;
        carry_s  = 1'b1;
        borrow_s = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            q_up_s[4*k +: 4] = carry_s ?
                ((q_r[4*k +: 4] == MAX_DIGIT) ? 4'd0 : (q_r[4*k +: 4] + 4'd1)) :
                q_r[4*k +: 4];
            q_dn_s[4*k +: 4] = borrow_s ?
                ((q_r[4*k +: 4] == 4'd0) ? MAX_DIGIT : (q_r[4*k +: 4] - 4'd1)) :
                q_r[4*k +: 4];
            carry_s  = carry_s & (q_r[4*k +: 4] == MAX_DIGIT);
            borrow_s = borrow_s & (q_r[4*k +: 4] == 4'd0);
        end
    end

    // Load value with out-of-range digits forced to zero and flagged.
    always_comb begin
        q_load_s   = '0;
        load_bad_s = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            q_load_s[4*k +: 4] = digit_valid(D[4*k +: 4]) ? D[4*k +: 4] : 4'd0;
            load_bad_s         = load_bad_s | ~digit_valid(D[4*k +: 4]);
        end
    end

    // End-of-range decodes of the registered count.
    always_comb begin
        at_max_s = 1'b1;
        at_min_s = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            at_max_s = at_max_s & (q_r[4*k +: 4] == MAX_DIGIT);
            at_min_s = at_min_s & (q_r[4*k +: 4] == 4'd0);
        end
    end

    assign step_up_s = CE & UP & ~DN;
    assign step_dn_s = CE & DN & ~UP;

    // Count state, terminal-count pulses and sticky load error.
    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            q_r        <= '0;
            tcu_r      <= 1'b0;
            tcd_r      <= 1'b0;
            load_err_r <= 1'b0;
        end else if (PL) begin
            q_r        <= q_load_s;
            tcu_r      <= 1'b0;
            tcd_r      <= 1'b0;
            load_err_r <= load_err_r | load_bad_s;
        end else if (step_up_s) begin
            if (at_max_s && SAT) begin
                q_r   <= q_r;
                tcu_r <= 1'b0;
            end else begin
                q_r   <= q_up_s;
                tcu_r <= at_max_s;
            end
            tcd_r <= 1'b0;
        end else if (step_dn_s) begin
            if (at_min_s && SAT) begin
                q_r   <= q_r;
                tcd_r <= 1'b0;
            end else begin
                q_r   <= q_dn_s;
                tcd_r <= at_min_s;
            end
            tcu_r <= 1'b0;
        end else begin
            q_r   <= q_r;
            tcu_r <= 1'b0;
            tcd_r <= 1'b0;
        end
    end

    assign Q        = q_r;
    assign TCU      = tcu_r;
    assign TCD      = tcd_r;
    assign LOAD_ERR = load_err_r;
    assign AT_MAX   = at_max_s;
    assign AT_MIN   = at_min_s;

endmodule

// File: tb/tb_multi_digit_bcd_counter.sv
// Randomised bench for multi_digit_bcd_counter: three parameterisations share
// the stimulus and are checked every cycle against an integer-valued model.
module tb_multi_digit_bcd_counter;

    logic        CLK  = 1'b0;
    logic        MR_N = 1'b1;
    logic [11:0] D    = 12'h000;
    logic        PL   = 1'b0;
    logic        CE   = 1'b0;
    logic        UP   = 1'b0;
    logic        DN   = 1'b0;

    logic [7:0]  q0;
    logic [7:0]  q1;
    logic [11:0] q2;
    logic [2:0]  tcu, tcd, amax, amin, lerr;
    logic [11:0] qa [3];

    int tests = 0;
    int fails = 0;
    bit checks_on = 1'b0;

    // inst0: 2 BCD digits wrap, inst1: 2 BCD digits saturate, inst2: 3 base-7 digits wrap
    multi_digit_bcd_counter #(.DIGITS(2), .RADIX(10), .SATURATE(0)) u0 (
        .CLK(CLK), .MR_N(MR_N), .D(D[7:0]), .PL(PL), .CE(CE), .UP(UP), .DN(DN),
        .Q(q0), .TCU(tcu[0]), .TCD(tcd[0]), .AT_MAX(amax[0]), .AT_MIN(amin[0]),
        .LOAD_ERR(lerr[0]));
    multi_digit_bcd_counter #(.DIGITS(2), .RADIX(10), .SATURATE(1)) u1 (
        .CLK(CLK), .MR_N(MR_N), .D(D[7:0]), .PL(PL), .CE(CE), .UP(UP), .DN(DN),
        .Q(q1), .TCU(tcu[1]), .TCD(tcd[1]), .AT_MAX(amax[1]), .AT_MIN(amin[1]),
        .LOAD_ERR(lerr[1]));
    multi_digit_bcd_counter #(.DIGITS(3), .RADIX(7), .SATURATE(0)) u2 (
        .CLK(CLK), .MR_N(MR_N), .D(D), .PL(PL), .CE(CE), .UP(UP), .DN(DN),
        .Q(q2), .TCU(tcu[2]), .TCD(tcd[2]), .AT_MAX(amax[2]), .AT_MIN(amin[2]),
        .LOAD_ERR(lerr[2]));

    assign qa[0] = {4'h0, q0};
    assign qa[1] = {4'h0, q1};
    assign qa[2] = q2;

    initial forever #5 CLK = ~CLK;

    function automatic int rad(input int i);
        return (i == 2) ? 7 : 10;
    endfunction
    function automatic int ndig(input int i);
        return (i == 2) ? 3 : 2;
    endfunction
    function automatic bit sat(input int i);
        return (i == 1);
    endfunction
    function automatic int maxv(input int i);
        int m = 1;
        for (int k = 0; k < ndig(i); k++) m = m * rad(i);
        return m - 1;
    endfunction
    // Integer count -> packed digit representation
    function automatic logic [11:0] enc(input int v, input int i);
        logic [11:0] q = 12'h000;
        for (int k = 0; k < ndig(i); k++) begin
            q[4*k +: 4] = 4'(v % rad(i));
            v = v / rad(i);
        end
        return q;
    endfunction
    function automatic int load_val(input int i, input logic [11:0] d, output bit bad);
        int v = 0;
        int mul = 1;
        int dg;
        bad = 1'b0;
        for (int k = 0; k < ndig(i); k++) begin
            dg = int'(d[4*k +: 4]);
            if (dg >= rad(i)) begin
                bad = 1'b1;
                dg = 0;
            end
            v = v + dg * mul;
            mul = mul * rad(i);
        end
        return v;
    endfunction

    int mval [3];
    bit mtcu [3];
    bit mtcd [3];
    bit merr [3];

    always @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            for (int i = 0; i < 3; i++) begin
                mval[i] = 0; mtcu[i] = 1'b0; mtcd[i] = 1'b0; merr[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                bit bad;
                mtcu[i] = 1'b0;
                mtcd[i] = 1'b0;
                if (PL) begin
                    mval[i] = load_val(i, D, bad);
                    merr[i] = merr[i] | bad;
                end else if (CE && UP && !DN) begin
                    if (mval[i] == maxv(i)) begin
                        if (!sat(i)) begin mval[i] = 0; mtcu[i] = 1'b1; end
                    end else mval[i] = mval[i] + 1;
                end else if (CE && DN && !UP) begin
                    if (mval[i] == 0) begin
                        if (!sat(i)) begin mval[i] = maxv(i); mtcd[i] = 1'b1; end
                    end else mval[i] = mval[i] - 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (checks_on) begin
            for (int i = 0; i < 3; i++) begin
                chk("model_q",      i, 32'(qa[i]),   32'(enc(mval[i], i)));
                chk("model_tcu",    i, 32'(tcu[i]),  32'(mtcu[i]));
                chk("model_tcd",    i, 32'(tcd[i]),  32'(mtcd[i]));
                chk("model_at_max", i, 32'(amax[i]), 32'(mval[i] == maxv(i)));
                chk("model_at_min", i, 32'(amin[i]), 32'(mval[i] == 0));
                chk("model_lerr",   i, 32'(lerr[i]), 32'(merr[i]));
            end
        end
    end

    task automatic cyc(input logic pl, input logic ce, input logic up, input logic dn,
                       input logic [11:0] d);
        PL = pl; CE = ce; UP = up; DN = dn; D = d;
        @(posedge CLK);
        #2;
    endtask

    initial begin
        logic [11:0] rd;
        #1 MR_N = 1'b0;
        #3 checks_on = 1'b1;
        // Reset values before any clock edge
        chk("rst_q", 0, 32'(q0), 32'h00);
        chk("rst_at_min", 0, 32'(amin[0]), 32'd1);
        chk("rst_at_max", 0, 32'(amax[0]), 32'd0);
        chk("rst_flags", 0, 32'({tcu[0], tcd[0], lerr[0]}), 32'd0);
        @(posedge CLK); #2;
        MR_N = 1'b1;

        // Up across the 99 boundary
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h098); chk("ld98", 0, 32'(q0), 32'h98);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 12'h000); chk("up99", 0, 32'(q0), 32'h99);
        chk("up99_tcu", 0, 32'(tcu[0]), 32'd0);
        chk("up99_at_max", 0, 32'(amax[0]), 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 12'h000); chk("up00", 0, 32'(q0), 32'h00);
        chk("up00_tcu", 0, 32'(tcu[0]), 32'd1);
        chk("sat_up_hold", 1, 32'(q1), 32'h99);
        chk("sat_up_tcu", 1, 32'(tcu[1]), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 12'h000); chk("up01", 0, 32'(q0), 32'h01);
        chk("up01_tcu", 0, 32'(tcu[0]), 32'd0);

        // Down across the 00 boundary
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h001); chk("ld01", 0, 32'(q0), 32'h01);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 12'h000); chk("dn00", 0, 32'(q0), 32'h00);
        chk("dn00_tcd", 0, 32'(tcd[0]), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 12'h000); chk("dn99", 0, 32'(q0), 32'h99);
        chk("dn99_tcd", 0, 32'(tcd[0]), 32'd1);
        chk("sat_dn_hold", 1, 32'(q1), 32'h00);
        chk("sat_dn_tcd", 1, 32'(tcd[1]), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 12'h000); chk("dn98", 0, 32'(q0), 32'h98);
        chk("dn98_tcd", 0, 32'(tcd[0]), 32'd0);

        // Priority and hold
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 12'h045); chk("pl_over_up", 0, 32'(q0), 32'h45);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 12'h000); chk("hold_both", 0, 32'(q0), 32'h45);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'h000); chk("hold_ce0", 0, 32'(q0), 32'h45);

        // Invalid load and sticky error
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h0A7); chk("bad_ld_q", 0, 32'(q0), 32'h07);
        chk("bad_ld_err", 0, 32'(lerr[0]), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h012); chk("good_ld_q", 0, 32'(q0), 32'h12);
        chk("err_sticky", 0, 32'(lerr[0]), 32'd1);
        MR_N = 1'b0; #1;
        chk("async_rst_q", 0, 32'(q0), 32'h00);
        chk("async_rst_err", 0, 32'(lerr[0]), 32'd0);
        @(posedge CLK); #2;
        MR_N = 1'b1;

        // Reset mid-count: next step starts from zero
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
        chk("cnt3", 0, 32'(q0), 32'h03);
        MR_N = 1'b0; #1; MR_N = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 12'h000); chk("after_rst", 0, 32'(q0), 32'h01);

        // Random phase
        for (int n = 0; n < 2000; n++) begin
            MR_N = ($urandom_range(0, 149) != 0);
            case ($urandom_range(0, 4))
                0: rd = 12'($urandom);
                1: rd = 12'h099;
                2: rd = 12'h000;
                3: rd = 12'h666;
                default: rd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                               4'($urandom_range(0, 6))};
            endcase
            cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                1'($urandom), 1'($urandom), rd);
        end
        MR_N = 1'b1;
        @(negedge CLK); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multi_digit_bcd_counter.md
MULTI_DIGIT_BCD_COUNTER -- requirements
Module: multi_digit_bcd_counter

Interface
REQ-001 Parameter DIGITS, default 4, number of cascaded 4-bit digits (1..8).
REQ-002 Parameter RADIX, default 10, modulus of each digit (2..16); 10 gives BCD.
REQ-003 Parameter SATURATE, default 0; 0 wraps at the end of range, 1 holds at the end of range.
REQ-004 CLK  input  1  single clock, all state updates on rising edge.
REQ-005 MR_N  input  1  master reset, asynchronous assert, active-low.
REQ-006 D  input  4*DIGITS  parallel load value, digit k in bits [4k+3:4k].
REQ-007 PL  input  1  synchronous parallel load, active-high.
REQ-008 CE  input  1  count enable, active-high.
REQ-009 UP  input  1  count-up request.
REQ-010 DN  input  1  count-down request.
REQ-011 Q  output  4*DIGITS  current count, digit k in bits [4k+3:4k].
REQ-012 TCU  output  1  registered one-cycle pulse on up-wrap.
REQ-013 TCD  output  1  registered one-cycle pulse on down-wrap.
REQ-014 AT_MAX  output  1  level, all digits equal RADIX-1.
REQ-015 AT_MIN  output  1  level, all digits equal 0.
REQ-016 LOAD_ERR  output  1  sticky flag, an out-of-range digit was loaded.

Function
REQ-017 Priority each edge: MR_N low, then PL, then counting; lower items are ignored while a higher one is active.
REQ-018 PL=1: each digit of Q takes the matching digit of D; any digit with value >= RADIX loads as 0 and sets LOAD_ERR.
REQ-019 Count step happens only when CE=1 and PL=0 and exactly one of UP, DN is 1; UP=DN=1 or UP=DN=0 holds Q.
REQ-020 Up step: digit 0 increments; a digit at RADIX-1 goes to 0 and carries into the next digit in the same cycle (full ripple, single-cycle latency).
REQ-021 Down step: digit 0 decrements; a digit at 0 goes to RADIX-1 and borrows from the next digit in the same cycle.
REQ-022 SATURATE=0: up step from all-max gives all-zero; TCU=1 in the next cycle only.
REQ-023 SATURATE=0: down step from all-zero gives all-max; TCD=1 in the next cycle only.
REQ-024 SATURATE=1: up step at all-max and down step at all-zero leave Q unchanged; TCU and TCD stay 0.
REQ-025 TCU and TCD are 0 in every cycle not covered by REQ-022/023, including load cycles.
REQ-026 AT_MAX and AT_MIN are combinational decodes of the registered Q and are valid in the same cycle as Q.
REQ-027 LOAD_ERR clears only on MR_N; a later valid load does not clear it.
REQ-028 Q updates exactly one cycle after the enabling edge; no combinational path from UP/DN/PL/D to Q.

Reset
REQ-029 MR_N low asynchronously forces Q=0, TCU=0, TCD=0 and LOAD_ERR=0, regardless of CLK.
REQ-030 During reset, AT_MIN=1 and AT_MAX=0.
REQ-031 Reset asserted mid-count aborts the step; the first step after MR_N rises counts from 0.
REQ-032 Reset release is sampled synchronously; the first edge with MR_N high may count or load.

Verification (DIGITS=2, RADIX=10, SATURATE=0 unless noted)
REQ-033 Reset: MR_N=0 pulse -> Q=8'h00, AT_MIN=1, TCU=TCD=LOAD_ERR=0.
REQ-034 Up across boundary: load 8'h98, CE=1 UP=1 for 3 edges -> Q=99, 00, 01; TCU=1 only in the cycle after 99->00.
REQ-035 Down across boundary: load 8'h01, CE=1 DN=1 for 3 edges -> Q=00, 99, 98; TCD=1 only in the cycle after 00->99.
REQ-036 Priority and hold: PL=1 with UP=1, D=8'h45 -> Q=45. Next, UP=DN=1 -> Q stays 45. Next, CE=0 UP=1 -> Q stays 45.
REQ-037 Invalid load: D=8'hA7 with PL=1 -> Q=8'h07 and LOAD_ERR=1. LOAD_ERR stays 1 after a valid load of 8'h12 and clears only on MR_N=0.
REQ-038 SATURATE=1: at Q=99, UP step -> Q stays 99 and TCU=0. At Q=00, DN step -> Q stays 00 and TCD=0.
